fn_rr_arbiter: RTL and testbench
================================

Name: fn_rr_arbiter

Overview:
Shares one instance of the team's 3-in/2-out mux-based function unit between NREQ requesters. The arbiter grants requesters round-robin and latches the winner's operand. It evaluates the operand through the function unit and holds a registered response until the consumer accepts it. It sits between the requesting blocks and the single function-unit datapath.

Parameters:
NREQ, 4, number of requesters; legal range 2..8, need not be a power of two.
ID_W, 2, width of the requester index; must equal ceil(log2(NREQ)).
CNT_W, 8, width of the completed-transaction counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req  input  NREQ  per-requester request level; held until acked
x_flat  input  3*NREQ  operands; requester i uses bits [3*i+2:3*i]
ack  output  NREQ  one-cycle grant pulse, one-hot or zero
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts the response
rsp_id  output  ID_W  index of the requester that owns the response
rsp_x  output  3  operand that was evaluated
rsp_y  output  2  function result
busy  output  1  high whenever the FSM is not in IDLE
txn_cnt  output  CNT_W  count of accepted responses, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, ptr=0.
- Reset values of outputs: ack=0, rsp_valid=0, rsp_id=0, rsp_x=0, rsp_y=0, busy=0, txn_cnt=0.
- Reset mid-transaction discards any pending response; no ack or response is replayed afterwards.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - req sampled only in IDLE.
  - If req!=0: the winner is the first set bit in search order ptr, ptr+1, ... NREQ-1, 0, ... (mod NREQ).
  - Latch winner index and its operand; ptr <= (winner+1) mod NREQ.
  - Next state EVAL.
  - If req==0: stay in IDLE.
- EVAL:
  - ack[winner]=1 for exactly this cycle (registered output).
  - Register rsp_x = latched operand, rsp_y = f(latched operand), rsp_id = winner, rsp_valid <= 1.
  - Next state RESP.
- RESP:
  - rsp_* are held stable while rsp_ready=0.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, txn_cnt <= txn_cnt+1, next state IDLE.
- Latency and throughput:
  - req sampled in IDLE at cycle n -> ack high at n+1, rsp_valid high at n+2.
  - Handshake at cycle m -> IDLE at m+1; a new grant may be decided at m+1.
  - Peak throughput: 1 transaction per 3 cycles.
- Requester rules:
  - A requester whose req and operand are still asserted when the FSM next reaches IDLE is treated as a new request. A requester must therefore drop or update req in the ack cycle.
  - Operand changes while not sampled are ignored.
- Function f(x), x = 0..7 -> y = 2, 1, 1, 2, 3, 1, 3, 0 (y[1] from mux on {x2,x1} over {~x0, ~x0, x0, ~x0}; y[0] over {~x0, 1, ~x0, x0}, indices 3..0).
- Only one grant is outstanding at a time; ack never has more than one bit set.

Decomposition:
- Shared package fn_arb_pkg: FSM state encoding (IDLE=2'd0, EVAL=2'd1, RESP=2'd2) and the 8-entry reference table of f for the bench.
- Sub-module fn_unit: combinational 3-to-2 function built from two 4:1 muxes, instantiated once.
- The round-robin search stays inline in fn_rr_arbiter.

Test Plan:
1. Single request: after reset, req=4'b0100, x for requester 2 = 3'b100 -> ack=4'b0100 one cycle later, then rsp_valid=1, rsp_id=2, rsp_x=4, rsp_y=2'b11, txn_cnt=1 after accept.
2. Exhaustive function check: requester 0 with x = 0..7 in turn, rsp_ready=1 -> rsp_y = 2, 1, 1, 2, 3, 1, 3, 0.
3. Fairness: req=4'b1111 held continuously (re-asserted after each ack), rsp_ready=1 -> grant order 0, 1, 2, 3, 0, 1, with one ack every 3 cycles.
4. Backpressure: rsp_ready=0 for 5 cycles while req=4'b0011 -> rsp_* stable, busy=1, no ack. Then rsp_ready=1 -> accept, IDLE, next grant goes to requester 1.
5. Reset in RESP: rst_n low for 1 cycle -> all outputs 0 and ptr=0 immediately. Then req=4'b1010 -> requester 1 granted.
6. Counter wrap with CNT_W=2: 5 accepted transactions -> txn_cnt=1.

Source files
------------

// File: rtl/fn_arb_pkg.sv
// Shared definitions for the round-robin function-unit arbiter: FSM encoding
// and a reference table of the 3-in/2-out function f.
package fn_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEval = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    // Entry x lives at bits [2*x+1:2*x]; f(0..7) = 2, 1, 1, 2, 3, 1, 3, 0.
    localparam logic [15:0] FnRef = {2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd1, 2'd1, 2'd2};

    function automatic logic [1:0] fn_ref(input logic [2:0] x);
        return FnRef[2*x +: 2];
    endfunction

endpackage

// File: rtl/fn_unit.sv
// Combinational 3-to-2 function unit: two 4:1 muxes selected by {x2, x1},
// with data inputs derived from x0.
module fn_unit (
    input  logic [2:0] x_i,
    output logic [1:0] y_o
);

    logic [3:0] mux_hi;
    logic [3:0] mux_lo;

    // Mux data listed as indices 3..0.
    assign mux_hi = {~x_i[0], ~x_i[0], x_i[0], ~x_i[0]};
    assign mux_lo = {~x_i[0], 1'b1, ~x_i[0], x_i[0]};

    assign y_o = {mux_hi[x_i[2:1]], mux_lo[x_i[2:1]]};

endmodule

// File: rtl/fn_rr_arbiter.sv
// Round-robin arbiter sharing one fn_unit between NREQ requesters; grants one
// requester at a time and holds a registered response until it is accepted.
module fn_rr_arbiter
    import fn_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_i,
    input  logic [3*NREQ-1:0] x_flat_i,
    output logic [NREQ-1:0]   ack_o,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [ID_W-1:0]   rsp_id_o,
    output logic [2:0]        rsp_x_o,
    output logic [1:0]        rsp_y_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  txn_cnt_o
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  win_q, win_d;
    logic [2:0]       opnd_q, opnd_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [2:0]       rsp_x_q, rsp_x_d;
    logic [1:0]       rsp_y_q, rsp_y_d;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;

    logic             found;
    logic [ID_W-1:0]  pick;
    logic [2:0]       pick_x;
    logic [1:0]       fn_y;

    fn_unit u_fn_unit (
        .x_i (opnd_q),
        .y_o (fn_y)
    );

    // First set request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        pick   = '0;
        pick_x = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                pick   = ID_W'(idx);
                pick_x = x_flat_i[3*idx +: 3];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        opnd_d      = opnd_q;
        ack_d       = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_x_d     = rsp_x_q;
        rsp_y_d     = rsp_y_q;
        txn_cnt_d   = txn_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    win_d   = pick;
                    opnd_d  = pick_x;
                    ptr_d   = (32'(pick) == NREQ - 1) ? '0 : pick + ID_W'(1);
                    ack_d   = NREQ'(1) << pick;
                    state_d = StEval;
                end
            end
            StEval: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = win_q;
                rsp_x_d     = opnd_q;
                rsp_y_d     = fn_y;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_valid_q && rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    txn_cnt_d   = txn_cnt_q + CNT_W'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            win_q       <= '0;
            opnd_q      <= '0;
            ack_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            txn_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            opnd_q      <= opnd_d;
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_x_q     <= rsp_x_d;
            rsp_y_q     <= rsp_y_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign ack_o       = ack_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_x_o     = rsp_x_q;
    assign rsp_y_o     = rsp_y_q;
    assign busy_o      = (state_q != StIdle);
    assign txn_cnt_o   = txn_cnt_q;

endmodule

// File: tb/tb_fn_rr_arbiter.sv
// Directed bench for fn_rr_arbiter; a second instance with CNT_W=2 shares the
// stimulus so its counter wrap can be observed.
module tb_fn_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] x_flat;
    logic        rsp_ready;

    logic [3:0]  ack;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [2:0]  rsp_x;
    logic [1:0]  rsp_y;
    logic        busy;
    logic [7:0]  txn_cnt;

    logic [3:0]  ack_w;
    logic        rsp_valid_w;
    logic [1:0]  rsp_id_w;
    logic [2:0]  rsp_x_w;
    logic [1:0]  rsp_y_w;
    logic        busy_w;
    logic [1:0]  txn_cnt_w;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] f_exp [8] = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0};

    fn_rr_arbiter #(.NREQ(4), .ID_W(2), .CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .x_flat_i    (x_flat),
        .ack_o       (ack),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_x_o     (rsp_x),
        .rsp_y_o     (rsp_y),
        .busy_o      (busy),
        .txn_cnt_o   (txn_cnt)
    );

    fn_rr_arbiter #(.NREQ(4), .ID_W(2), .CNT_W(2)) dut_wrap (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .x_flat_i    (x_flat),
        .ack_o       (ack_w),
        .rsp_valid_o (rsp_valid_w),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id_w),
        .rsp_x_o     (rsp_x_w),
        .rsp_y_o     (rsp_y_w),
        .busy_o      (busy_w),
        .txn_cnt_o   (txn_cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".ack"}, 32'(ack), 32'h0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, ".rsp_id"}, 32'(rsp_id), 32'h0);
        chk({tag, ".rsp_x"}, 32'(rsp_x), 32'h0);
        chk({tag, ".rsp_y"}, 32'(rsp_y), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".txn_cnt"}, 32'(txn_cnt), 32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        x_flat    = '0;
        rsp_ready = 1'b0;
        step();
        step();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        step();
        chk("post_reset.ack", 32'(ack), 32'h0);

        // 1: single request from requester 2 with x = 4.
        x_flat[8:6] = 3'b100;
        req         = 4'b0100;
        step();
        chk("t1.ack", 32'(ack), 32'h4);
        chk("t1.busy", 32'(busy), 32'h1);
        chk("t1.rsp_valid_early", 32'(rsp_valid), 32'h0);
        req = 4'b0000;
        step();
        chk("t1.ack_clear", 32'(ack), 32'h0);
        chk("t1.rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1.rsp_id", 32'(rsp_id), 32'h2);
        chk("t1.rsp_x", 32'(rsp_x), 32'h4);
        chk("t1.rsp_y", 32'(rsp_y), 32'h3);
        rsp_ready = 1'b1;
        step();
        chk("t1.rsp_valid_done", 32'(rsp_valid), 32'h0);
        chk("t1.txn_cnt", 32'(txn_cnt), 32'h1);
        chk("t1.busy_done", 32'(busy), 32'h0);

        // 2: every operand through requester 0.
        for (int v = 0; v < 8; v++) begin
            x_flat[2:0] = 3'(v);
            req         = 4'b0001;
            step();
            chk($sformatf("t2.ack[%0d]", v), 32'(ack), 32'h1);
            req = 4'b0000;
            step();
            chk($sformatf("t2.rsp_id[%0d]", v), 32'(rsp_id), 32'h0);
            chk($sformatf("t2.rsp_x[%0d]", v), 32'(rsp_x), 32'(v));
            chk($sformatf("t2.rsp_y[%0d]", v), 32'(rsp_y), 32'(f_exp[v]));
            step();
        end
        chk("t2.txn_cnt", 32'(txn_cnt), 32'd9);

        // 3: fairness with all requests held, starting from ptr = 0.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        x_flat = 12'b011_010_001_000;
        req    = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("t3.ack[%0d]", i), 32'(ack), 32'(1 << (i % 4)));
            step();
            chk($sformatf("t3.ack_gap[%0d]", i), 32'(ack), 32'h0);
            chk($sformatf("t3.rsp_id[%0d]", i), 32'(rsp_id), 32'(i % 4));
            chk($sformatf("t3.rsp_x[%0d]", i), 32'(rsp_x), 32'(i % 4));
            step();
            chk($sformatf("t3.idle_ack[%0d]", i), 32'(ack), 32'h0);
        end
        chk("t3.txn_cnt", 32'(txn_cnt), 32'd6);

        // 4: backpressure; ptr is 2, so requester 0 wins first, then 1.
        req         = 4'b0011;
        rsp_ready   = 1'b0;
        x_flat[2:0] = 3'b110;
        step();
        chk("t4.ack0", 32'(ack), 32'h1);
        step();
        chk("t4.rsp_id", 32'(rsp_id), 32'h0);
        x_flat[2:0] = 3'b001;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t4.hold_valid[%0d]", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("t4.hold_x[%0d]", i), 32'(rsp_x), 32'h6);
            chk($sformatf("t4.hold_y[%0d]", i), 32'(rsp_y), 32'h3);
            chk($sformatf("t4.hold_busy[%0d]", i), 32'(busy), 32'h1);
            chk($sformatf("t4.hold_ack[%0d]", i), 32'(ack), 32'h0);
        end
        rsp_ready = 1'b1;
        step();
        chk("t4.accept_valid", 32'(rsp_valid), 32'h0);
        chk("t4.accept_busy", 32'(busy), 32'h0);
        chk("t4.txn_cnt", 32'(txn_cnt), 32'd7);
        step();
        chk("t4.ack1", 32'(ack), 32'h2);
        req = 4'b0000;
        step();
        chk("t4.rsp_id1", 32'(rsp_id), 32'h1);
        step();
        chk("t4.txn_cnt2", 32'(txn_cnt), 32'd8);

        // 5: reset while a response is pending.
        req       = 4'b0100;
        rsp_ready = 1'b0;
        step();
        req = 4'b0000;
        step();
        chk("t5.pending", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t5.reset");
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        step();
        chk("t5.no_replay_ack", 32'(ack), 32'h0);
        chk("t5.no_replay_valid", 32'(rsp_valid), 32'h0);
        req = 4'b1010;
        step();
        chk("t5.ack", 32'(ack), 32'h2);
        req = 4'b0000;
        step();
        chk("t5.rsp_id", 32'(rsp_id), 32'h1);
        step();
        chk("t5.txn_cnt", 32'(txn_cnt), 32'd1);

        // 6: four more accepts gives five since reset; 2-bit counter wraps to 1.
        for (int i = 0; i < 4; i++) begin
            req = 4'b0001;
            step();
            req = 4'b0000;
            step();
            step();
        end
        chk("t6.txn_cnt8", 32'(txn_cnt), 32'd5);
        chk("t6.txn_cnt2", 32'(txn_cnt_w), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
